// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and defaults for the serial receiver
//
// Purpose: receiver FSM state encoding and the default word length.
// Ports:   none (package).

package serial_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'b00,
    RX_RECEIVE = 2'b01,
    RX_HOLD    = 2'b10
  } rx_state_t;

  localparam int RX_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/serial_rx_reg_if.sv
// rtl/serial_rx_reg_if.sv - handshake/data bundle between a serial source and the receiver
//
// Purpose: groups the serial input, the start/ack handshake and the word outputs.
// Ports (signals):
//   start - request to begin capturing one word
//   S     - serial data in, one bit per clock
//   ack   - consumer accepts the word on Q
//   Q     - last completed word (WIDTH bits)
//   valid - Q holds an unacknowledged word
//   busy  - capture in progress
//   ovr   - sticky overrun flag
// Modports: master = source/consumer side, slave = receiver side.

interface serial_rx_reg_if
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = RX_DEFAULT_WIDTH
);

  logic             start;
  logic             S;
  logic             ack;
  logic [WIDTH-1:0] Q;
  logic             valid;
  logic             busy;
  logic             ovr;

  modport master (
    output start, S, ack,
    input  Q, valid, busy, ovr
  );

  modport slave (
    input  start, S, ack,
    output Q, valid, busy, ovr
  );

endinterface

// File: rtl/serial_rx_reg.sv
// rtl/serial_rx_reg.sv - serial-in/parallel-out word receiver with valid/ack handshake
//
// Purpose: after a start request, shifts in WIDTH bits from S (one per clock) and
//          presents the completed word on Q until it is acknowledged.
// Ports:
//   clk   - system clock, rising edge
//   res_n - asynchronous active-low reset
//   bus   - serial_rx_reg_if.slave (start, S, ack in; Q, valid, busy, ovr out)
// Parameters:
//   WIDTH     - word length in bits (>= 2)
//   MSB_FIRST - 1: first received bit lands in Q[WIDTH-1]; 0: lands in Q[0]

module serial_rx_reg
  import serial_rx_pkg::*;
#(
  parameter int WIDTH     = RX_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            res_n,
  serial_rx_reg_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state;
  rx_state_t        state_nx;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // Shift register contents including the bit presented on S this cycle; on the
  // final bit this is the completed word, so Q is loaded straight from it.
  always_comb begin
    shifted = MSB_FIRST ? {sreg[WIDTH-2:0], bus.S} : {bus.S, sreg[WIDTH-1:1]};
  end

  assign last_bit = (cnt == LAST);

  // valid and busy decode directly from the state, so they can never both be
  // high and they drop together with the state on an asynchronous reset.
  assign bus.busy  = (state == RX_RECEIVE);
  assign bus.valid = (state == RX_HOLD);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:    if (bus.start) state_nx = RX_RECEIVE;
      RX_RECEIVE: if (last_bit)  state_nx = RX_HOLD;
      // ack together with start goes straight back to RECEIVE (no idle gap).
      RX_HOLD:    if (bus.ack)   state_nx = bus.start ? RX_RECEIVE : RX_IDLE;
      default:    state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sreg    <= '0;
      cnt     <= '0;
      bus.Q   <= '0;
      bus.ovr <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (bus.start) cnt <= '0;
        end
        RX_RECEIVE: begin
          sreg <= shifted;
          cnt  <= cnt + 1'b1;
          if (last_bit) bus.Q <= shifted;
        end
        RX_HOLD: begin
          if (bus.ack) begin
            bus.ovr <= 1'b0;
            if (bus.start) cnt <= '0;
          end else if (bus.start) begin
            // Start while the word is still unacknowledged is dropped and flagged.
            bus.ovr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_reg.sv
// tb/tb_serial_rx_reg.sv - self-checking bench for serial_rx_reg (MSB-first and LSB-first)

module tb_serial_rx_reg;

  localparam int W = 16;

  logic clk = 1'b0;
  logic res_n;
  logic start;
  logic S;
  logic ack;

  always #5 clk = ~clk;

  serial_rx_reg_if #(.WIDTH(W)) if_m ();
  serial_rx_reg_if #(.WIDTH(W)) if_l ();

  assign if_m.start = start;
  assign if_m.S     = S;
  assign if_m.ack   = ack;
  assign if_l.start = start;
  assign if_l.S     = S;
  assign if_l.ack   = ack;

  serial_rx_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if_m.slave)
  );

  serial_rx_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if_l.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] l;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: bits[i] is the i-th bit on the wire (i = 0 first).
  function automatic logic [W-1:0] model_word(input logic [W-1:0] bits, input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = bits[i];
      else           w[i]     = bits[i];
    end
    return w;
  endfunction

  // Wire order for sending a word MSB first.
  function automatic logic [W-1:0] msb_order(input logic [W-1:0] w);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = w[W-1-i];
    return b;
  endfunction

  // Serial output of a left-shifting register loaded with 'load': F is its top bit.
  function automatic logic [W-1:0] usr_stream(input logic [W-1:0] load);
    logic [W-1:0] r;
    logic [W-1:0] b;
    r = load;
    for (int i = 0; i < W; i++) begin
      b[i] = r[W-1];
      r    = {r[W-2:0], 1'b0};
    end
    return b;
  endfunction

  // Monitor: on each new word, compare both receivers against the scoreboard.
  logic prev_v = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (if_m.valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("q_msb_first", 32'(if_m.Q), 32'(e.m));
        chk("q_lsb_first", 32'(if_l.Q), 32'(e.l));
        chk("valid_lsb", 32'(if_l.valid), 32'd1);
        chk("busy_valid_excl", {30'd0, if_m.busy, if_m.valid}, 32'd1);
      end
    end
    prev_v <= if_m.valid;
  end

  // start (optionally with ack) then W bits; mid >= 0 pulses start during capture.
  task automatic send_word(input logic [W-1:0] bits, input bit with_ack, input int mid);
    exp_t x;
    x.m = model_word(bits, 1'b1);
    x.l = model_word(bits, 1'b0);
    exp_q.push_back(x);
    start = 1'b1;
    ack   = with_ack;
    @(posedge clk); #1;
    ack = 1'b0;
    for (int i = 0; i < W; i++) begin
      start = (i == mid);
      S     = bits[i];
      chk("capture_busy", {30'd0, if_m.busy, if_m.valid}, 32'd2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_valid", {30'd0, if_m.busy, if_m.valid}, 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("ack_valid", 32'(if_m.valid), 32'd0);
    chk("ack_ovr", 32'(if_m.ovr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bits;
    bit b2b;
    int mid;

    res_n = 1'b0;
    start = 1'b0;
    S     = 1'b0;
    ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 32'(if_m.Q), 32'd0);
    chk("rst_flags", {29'd0, if_m.valid, if_m.busy, if_m.ovr}, 32'd0);
    res_n = 1'b1;
    @(posedge clk); #1;

    // MSB first A5C3, Q holds until ack
    send_word(msb_order(16'hA5C3), 1'b0, -1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_q", 32'(if_m.Q), 32'hA5C3);
    end
    do_ack();
    chk("idle_busy", 32'(if_m.busy), 32'd0);

    // LSB first A5C3 (LSB-first receiver must see A5C3)
    send_word(16'hA5C3, 1'b0, -1);
    do_ack();

    // back-to-back
    send_word(msb_order(16'h0001), 1'b0, -1);
    send_word(msb_order(16'hFFFF), 1'b1, -1);
    chk("b2b_q", 32'(if_m.Q), 32'hFFFF);
    do_ack();

    // overrun
    send_word(msb_order(16'h1234), 1'b0, -1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ovr_set", 32'(if_m.ovr), 32'd1);
    chk("ovr_set_lsb", 32'(if_l.ovr), 32'd1);
    chk("ovr_q", 32'(if_m.Q), 32'h1234);
    chk("ovr_vb", {30'd0, if_m.busy, if_m.valid}, 32'd1);
    @(posedge clk); #1;
    chk("ovr_sticky", 32'(if_m.ovr), 32'd1);
    do_ack();

    // reset mid-capture, no clock edge needed
    bits  = msb_order(16'hBEEF);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      S = bits[i];
      @(posedge clk); #1;
    end
    #2;
    res_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(if_m.Q), 32'd0);
    chk("async_rst_flags", {29'd0, if_m.valid, if_m.busy, if_m.ovr}, 32'd0);
    @(posedge clk); #1;
    res_n = 1'b1;
    send_word(bits, 1'b0, -1);
    chk("after_rst_q", 32'(if_m.Q), 32'hBEEF);
    do_ack();

    // loopback from a shift register loaded with C0DE, stray start mid-stream
    send_word(usr_stream(16'hC0DE), 1'b0, 7);
    chk("loop_q", 32'(if_m.Q), 32'hC0DE);
    chk("loop_ovr", 32'(if_m.ovr), 32'd0);
    do_ack();

    // randomized words, gaps, back-to-back and stray starts
    for (int n = 0; n < 24; n++) begin
      bits = W'($urandom);
      b2b  = (n > 0) && ($urandom_range(0, 1) == 1);
      mid  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
      if (n > 0 && !b2b) begin
        do_ack();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      send_word(bits, b2b, mid);
    end
    do_ack();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
